wb_forward_source: RTL

//   Producer side of the operand-forwarding path in the 3-stage RV32I pipeline.

---
 rtl/wb_forward_source.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_forward_source.sv
// wb_forward_source: stage-3 register, writeback and forward-data producer for
// the 3-stage RV32I pipeline. Tags the pending write (rd, has_rd, is_load),
// drives the ALU/load forward buses, and stalls the front of the pipe while a
// stage-3 load waits on data memory.
module wb_forward_source #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s2_valid,
   input  logic [31:0]      s2_inst,
   input  logic [XLEN-1:0]  s2_result,
   input  logic             flush,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             s3_valid,
   output logic [RA_W-1:0]  s3_rd,
   output logic             s3_has_rd,
   output logic             s3_is_load,
   output logic [XLEN-1:0]  fwd_alu_data,
   output logic [XLEN-1:0]  fwd_load_data,
   output logic             fwd_load_valid,
   output logic             stall,
   output logic             rf_we,
   output logic [RA_W-1:0]  rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {ST_RUN, ST_LOAD_WAIT} state_t;

   state_t          state;
   logic [6:0]      dec_opcode;
   logic [RA_W-1:0] dec_rd;
   logic            dec_has_rd;
   logic            dec_is_load;
   logic            capture_load;
   logic            load_data_now;

   // Decode the stage-2 instruction into the tags carried into stage 3.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      dec_opcode  = s2_inst[6:0];
      dec_rd      = s2_inst[7 +: RA_W];
      dec_has_rd  = 1'b1;
      if (dec_opcode == OP_BRANCH || dec_opcode == OP_STORE || dec_rd == '0)
         dec_has_rd = 1'b0;
      dec_is_load = (dec_opcode == OP_LOAD);
   end

   // A load arrives at stage 3 only when the pipe is moving and the slot is live.
   assign capture_load  = ~stall & s2_valid & ~flush & dec_is_load;
   // Data for the stage-3 load is present this cycle; spurious rvalid in RUN is ignored.
   assign load_data_now = (state == ST_LOAD_WAIT) & dmem_rvalid;
   // Stall releases in the same cycle the load data shows up.
   assign stall         = (state == ST_LOAD_WAIT) & ~dmem_rvalid;

   // Stage-3 register and load-wait FSM; reset drops any outstanding load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state        <= ST_RUN;
         s3_valid     <= 1'b0;
         s3_rd        <= '0;
         s3_has_rd    <= 1'b0;
         s3_is_load   <= 1'b0;
         fwd_alu_data <= '0;
      end else begin
         if (!stall) begin
            s3_valid     <= s2_valid & ~flush;
            s3_rd        <= dec_rd;
            s3_has_rd    <= dec_has_rd;
            s3_is_load   <= dec_is_load;
            fwd_alu_data <= s2_result;
         end
         case (state)
            ST_RUN:       if (capture_load) state <= ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (dmem_rvalid && !capture_load) state <= ST_RUN;
            default:      state <= ST_RUN;
         endcase
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stall && stall_cycles != '1)
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

   // Writeback: non-loads write while live; loads write only in their data cycle.
   always_comb begin
      rf_we = 1'b0;
      if (s3_valid && s3_has_rd)
         rf_we = s3_is_load ? load_data_now : 1'b1;
   end

   assign rf_waddr       = s3_rd;
   assign rf_wdata       = s3_is_load ? dmem_rdata : fwd_alu_data;
   assign fwd_load_data  = dmem_rdata;
   assign fwd_load_valid = load_data_now;

endmodule
